// File: rtl/xoodoo_pkg.sv
// rtl/xoodoo_pkg.sv - shared constants, FSM encoding and helpers for the Xoodoo permutation engine
package xoodoo_pkg;

    localparam int XOO_STATE_W    = 384;
    localparam int XOO_MAX_ROUNDS = 12;

    // Round constants of Xoodoo[12], first round first; an n-round job uses the last n entries.
    localparam logic [31:0] RC_ROM [12] = '{
        32'h0000_0058, 32'h0000_0038, 32'h0000_03C0, 32'h0000_00D0,
        32'h0000_0120, 32'h0000_0014, 32'h0000_0060, 32'h0000_002C,
        32'h0000_0380, 32'h0000_00F0, 32'h0000_01A0, 32'h0000_0012
    };

    typedef enum logic [1:0] {
        XS_IDLE = 2'd0,
        XS_RUN  = 2'd1,
        XS_DONE = 2'd2
    } xoo_fsm_e;

    // One final round (rc 0x12) applied to the all-zero state.
    localparam logic [XOO_STATE_W-1:0] XOO_GOLD_ZERO_R1 = {
        32'h0, 32'h0, 32'h0, 32'h0,
        32'h0, 32'h0, 32'h0, 32'h0000_0024,
        32'h0, 32'h0, 32'h0, 32'h0000_0012
    };

    // One final round applied to a state whose only set bit is bit 0 of plane 0 lane 0.
    localparam logic [XOO_STATE_W-1:0] XOO_GOLD_LANE0_R1 = {
        32'h0100_0002, 32'h0,           32'h0,           32'h0040_2000,
        32'h0,         32'h0000_8040,   32'h0000_8040,   32'h0000_0026,
        32'h0,         32'h0,           32'h0201_4020,   32'h0000_0013
    };

    function automatic logic [31:0] xoo_rotl(input logic [31:0] v, input int unsigned k);
        return (v << k) | (v >> (32 - k));
    endfunction

    // Out-of-range indices only occur while the round chain output is ignored.
    function automatic logic [31:0] xoo_rc(input logic [3:0] k);
        return (k < 4'd12) ? RC_ROM[k] : 32'h0;
    endfunction

endpackage

// File: rtl/xoodoo_round.sv
// rtl/xoodoo_round.sv - one combinational Xoodoo round; lane (y,x) sits at bits [(4*y+x)*32 +: 32]
module xoodoo_round
    import xoodoo_pkg::*;
(
    input  logic [XOO_STATE_W-1:0] state_in,
    input  logic [31:0]            rc,
    output logic [XOO_STATE_W-1:0] state_out
);

    logic [11:0][31:0] a, w, c, o;
    logic [3:0][31:0]  p, e;

    always_comb begin
        a = state_in;
        p = '0;
        e = '0;
        w = '0;
        c = '0;
        o = '0;
        for (int x = 0; x < 4; x++) begin
            p[x] = a[x] ^ a[4+x] ^ a[8+x];
        end
        for (int x = 0; x < 4; x++) begin
            e[x] = xoo_rotl(p[(x+3)%4], 5) ^ xoo_rotl(p[(x+3)%4], 14);
        end
        for (int i = 0; i < 12; i++) begin
            a[i] = a[i] ^ e[i%4];
        end
        // rho-west: plane 1 shifts one lane east, plane 2 rotates by 11
        for (int x = 0; x < 4; x++) begin
            w[x]   = a[x];
            w[4+x] = a[4+(x+3)%4];
            w[8+x] = xoo_rotl(a[8+x], 11);
        end
        w[0] = w[0] ^ rc;
        for (int x = 0; x < 4; x++) begin
            c[x]   = w[x]   ^ (~w[4+x] & w[8+x]);
            c[4+x] = w[4+x] ^ (~w[8+x] & w[x]);
            c[8+x] = w[8+x] ^ (~w[x]   & w[4+x]);
        end
        // rho-east: plane 1 rotates by 1, plane 2 shifts two lanes and rotates by 8
        for (int x = 0; x < 4; x++) begin
            o[x]   = c[x];
            o[4+x] = xoo_rotl(c[4+x], 1);
            o[8+x] = xoo_rotl(c[8+(x+2)%4], 8);
        end
        state_out = o;
    end

endmodule

// File: rtl/xoodoo_perm_engine.sv
// rtl/xoodoo_perm_engine.sv - iterative handshaked Xoodoo[n] core, ROUNDS_PER_CYCLE rounds per clock
module xoodoo_perm_engine
    import xoodoo_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [XOO_STATE_W-1:0] in_state,
    input  logic [3:0]             in_nrounds,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XOO_STATE_W-1:0] out_state,
    output logic                   busy,
    output logic                   err
);

    if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 3 ||
          ROUNDS_PER_CYCLE == 4 || ROUNDS_PER_CYCLE == 6 || ROUNDS_PER_CYCLE == 12)) begin : g_bad_rpc
        $error("ROUNDS_PER_CYCLE must be one of 1, 2, 3, 4, 6, 12");
    end

    xoo_fsm_e                fsm_q, fsm_d;
    logic [XOO_STATE_W-1:0]  state_q, state_d;
    logic [3:0]              idx_q, idx_d, idx_step;
    logic                    err_q, err_d;
    logic                    n_legal;

    logic [ROUNDS_PER_CYCLE:0][XOO_STATE_W-1:0] chain;

    assign chain[0] = state_q;
    for (genvar r = 0; r < ROUNDS_PER_CYCLE; r++) begin : g_round
        xoodoo_round u_round (
            .state_in  (chain[r]),
            .rc        (xoo_rc(idx_q + 4'(r))),
            .state_out (chain[r+1])
        );
    end

    // A multiple of the unroll factor guarantees the index lands exactly on 12.
    assign n_legal  = (in_nrounds != 4'd0) && (in_nrounds <= 4'(XOO_MAX_ROUNDS)) &&
                      ((32'(in_nrounds) % ROUNDS_PER_CYCLE) == 0);
    assign idx_step = idx_q + 4'(ROUNDS_PER_CYCLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q   <= XS_IDLE;
            state_q <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        idx_d   = idx_q;
        err_d   = 1'b0;
        case (fsm_q)
            XS_IDLE: begin
                if (in_valid) begin
                    if (n_legal) begin
                        state_d = in_state;
                        idx_d   = 4'(XOO_MAX_ROUNDS) - in_nrounds;
                        fsm_d   = XS_RUN;
                    end else begin
                        err_d   = 1'b1;
                    end
                end
            end
            XS_RUN: begin
                state_d = chain[ROUNDS_PER_CYCLE];
                idx_d   = idx_step;
                if (idx_step == 4'(XOO_MAX_ROUNDS)) begin
                    fsm_d = XS_DONE;
                end
            end
            XS_DONE: begin
                if (out_ready) begin
                    fsm_d = XS_IDLE;
                end
            end
            default: fsm_d = XS_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (fsm_q)
            XS_IDLE: in_ready = 1'b1;
            XS_RUN:  busy     = 1'b1;
            XS_DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: ;
        endcase
    end

    assign out_state = state_q;
    assign err       = err_q;

endmodule

// File: tb/tb_xoodoo_perm_engine.sv
// tb/tb_xoodoo_perm_engine.sv - self-checking bench for xoodoo_perm_engine across four unroll factors
module tb_xoodoo_perm_engine;
    import xoodoo_pkg::*;

    localparam int NI = 4;

    function automatic int rpc_of(input int i);
        return (i == 0) ? 1 : (i == 1) ? 2 : (i == 2) ? 4 : 12;
    endfunction

    localparam logic [31:0] TB_RC [12] = '{
        32'h058, 32'h038, 32'h3C0, 32'h0D0, 32'h120, 32'h014,
        32'h060, 32'h02C, 32'h380, 32'h0F0, 32'h1A0, 32'h012
    };

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NI-1:0]        in_valid  = '0;
    logic [NI-1:0]        out_ready = '1;
    logic [NI-1:0][3:0]   in_nrounds = '0;
    logic [NI-1:0][383:0] in_state = '0;
    logic [NI-1:0]        in_ready_w, out_valid_w, busy_w, err_w;
    logic [NI-1:0][383:0] out_state_w;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        xoodoo_perm_engine #(.ROUNDS_PER_CYCLE(rpc_of(g))) u_dut (
            .clk        (clk),
            .rst        (rst),
            .in_valid   (in_valid[g]),
            .in_ready   (in_ready_w[g]),
            .in_state   (in_state[g]),
            .in_nrounds (in_nrounds[g]),
            .out_valid  (out_valid_w[g]),
            .out_ready  (out_ready[g]),
            .out_state  (out_state_w[g]),
            .busy       (busy_w[g]),
            .err        (err_w[g])
        );
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int k, input logic [383:0] got, input logic [383:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h required %h", name, k, got, exp);
        end
    endtask

    task automatic timeout(input string name, input int k);
        n_checks++;
        n_fail++;
        $display("FAIL %s[%0d]: wait budget expired", name, k);
    endtask

    function automatic logic [31:0] rl(input logic [31:0] v, input int s);
        return (v << s) | (v >> (32 - s));
    endfunction

    // Reference Xoodoo[n]: the last n rounds of Xoodoo[12] on a 3x4 lane array.
    function automatic logic [383:0] xoo_perm(input logic [383:0] s, input int n);
        logic [31:0] a [3][4];
        logic [31:0] b [3][4];
        logic [31:0] p [4];
        logic [31:0] t [4];
        logic [383:0] r;
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 4; x++)
                a[y][x] = s[(4*y+x)*32 +: 32];
        for (int rd = 12 - n; rd < 12; rd++) begin
            for (int x = 0; x < 4; x++) p[x] = a[0][x] ^ a[1][x] ^ a[2][x];
            for (int x = 0; x < 4; x++) t[x] = rl(p[(x+3)%4], 5) ^ rl(p[(x+3)%4], 14);
            for (int y = 0; y < 3; y++)
                for (int x = 0; x < 4; x++) a[y][x] = a[y][x] ^ t[x];
            for (int x = 0; x < 4; x++) t[x] = a[1][x];
            for (int x = 0; x < 4; x++) a[1][x] = t[(x+3)%4];
            for (int x = 0; x < 4; x++) a[2][x] = rl(a[2][x], 11);
            a[0][0] = a[0][0] ^ TB_RC[rd];
            for (int y = 0; y < 3; y++)
                for (int x = 0; x < 4; x++) b[y][x] = ~a[(y+1)%3][x] & a[(y+2)%3][x];
            for (int y = 0; y < 3; y++)
                for (int x = 0; x < 4; x++) a[y][x] = a[y][x] ^ b[y][x];
            for (int x = 0; x < 4; x++) a[1][x] = rl(a[1][x], 1);
            for (int x = 0; x < 4; x++) t[x] = a[2][x];
            for (int x = 0; x < 4; x++) a[2][x] = rl(t[(x+2)%4], 8);
        end
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 4; x++)
                r[(4*y+x)*32 +: 32] = a[y][x];
        return r;
    endfunction

    function automatic bit legal(input int k, input int n);
        return (n >= 1) && (n <= 12) && (n % rpc_of(k) == 0);
    endfunction

    // Transaction-level expectation: busy for n/RPC cycles, then holding a result until taken.
    bit           m_active [NI];
    int           m_rem    [NI];
    bit           m_err    [NI];
    logic [383:0] m_exp    [NI];

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < NI; k++) begin
            if (rst) begin
                m_active[k] <= 1'b0;
                m_rem[k]    <= 0;
                m_err[k]    <= 1'b0;
            end else if (!m_active[k]) begin
                m_err[k] <= in_valid[k] && !legal(k, int'(in_nrounds[k]));
                if (in_valid[k] && legal(k, int'(in_nrounds[k]))) begin
                    m_active[k] <= 1'b1;
                    m_rem[k]    <= int'(in_nrounds[k]) / rpc_of(k);
                    m_exp[k]    <= xoo_perm(in_state[k], int'(in_nrounds[k]));
                end
            end else begin
                m_err[k] <= 1'b0;
                if (m_rem[k] != 0) m_rem[k] <= m_rem[k] - 1;
                else if (out_ready[k]) m_active[k] <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            check("in_ready", k, in_ready_w[k], !m_active[k]);
            check("busy", k, busy_w[k], m_active[k]);
            check("out_valid", k, out_valid_w[k], m_active[k] && (m_rem[k] == 0));
            check("err", k, err_w[k], m_err[k]);
            if (m_active[k] && m_rem[k] == 0) check("out_state", k, out_state_w[k], m_exp[k]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int k);
        int c = 0;
        while (m_active[k] && c < 60) begin
            tick();
            c++;
        end
        if (m_active[k]) timeout("wait_idle", k);
    endtask

    task automatic send(input int k, input logic [383:0] st, input int n);
        wait_idle(k);
        in_state[k]   = st;
        in_nrounds[k] = 4'(n);
        in_valid[k]   = 1'b1;
        tick();
        in_valid[k]   = 1'b0;
    endtask

    task automatic wait_out(input int k, output int cyc, output logic [383:0] st);
        cyc = 0;
        st  = '0;
        while (!out_valid_w[k] && cyc < 40) begin
            tick();
            cyc++;
        end
        if (!out_valid_w[k]) timeout("wait_out", k);
        else st = out_state_w[k];
    endtask

    function automatic logic [383:0] rand_state();
        logic [383:0] s;
        for (int w = 0; w < 12; w++) s[w*32 +: 32] = $urandom;
        return s;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int           cyc;
        int           n;
        logic [383:0] st, hold, gold12, s2;

        repeat (3) tick();
        rst = 1'b0;
        tick();

        check("model_zero_r1", -1, xoo_perm('0, 1), XOO_GOLD_ZERO_R1);
        check("model_lane0_r1", -1, xoo_perm(384'd1, 1), XOO_GOLD_LANE0_R1);

        send(0, '0, 1);
        wait_out(0, cyc, st);
        check("lat_rpc1_n1", 0, cyc, 1);
        check("dut_zero_r1", 0, st, XOO_GOLD_ZERO_R1);
        send(0, 384'd1, 1);
        wait_out(0, cyc, st);
        check("dut_lane0_r1", 0, st, XOO_GOLD_LANE0_R1);

        send(1, '0, 12);
        wait_out(1, cyc, gold12);
        check("lat_rpc2_n12", 1, cyc, 6);
        check("dut_zero_r12", 1, gold12, xoo_perm('0, 12));

        foreach (TB_RC[i]) if (i < 3) begin
            n = (i == 0) ? 3 : (i == 1) ? 0 : 13;
            wait_idle(1);
            send(1, '1, n);
            check("err_pulse", 1, err_w[1], 1'b1);
            check("err_in_ready", 1, in_ready_w[1], 1'b1);
        end
        tick();
        check("err_drop", 1, err_w[1], 1'b0);

        out_ready[1] = 1'b0;
        s2 = rand_state();
        send(1, s2, 4);
        wait_out(1, cyc, hold);
        check("bp_result", 1, hold, xoo_perm(s2, 4));
        in_state[1]   = rand_state();
        in_nrounds[1] = 4'd2;
        in_valid[1]   = 1'b1;
        repeat (10) begin
            tick();
            check("bp_stable", 1, out_state_w[1], hold);
            check("bp_in_ready", 1, in_ready_w[1], 1'b0);
        end
        in_valid[1]  = 1'b0;
        out_ready[1] = 1'b1;
        tick();
        check("bp_release_ready", 1, in_ready_w[1], 1'b1);
        check("bp_release_valid", 1, out_valid_w[1], 1'b0);
        s2 = rand_state();
        send(1, s2, 2);
        wait_out(1, cyc, st);
        check("bp_next_job", 1, st, xoo_perm(s2, 2));

        send(1, '0, 12);
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("rst_out_valid", 1, out_valid_w[1], 1'b0);
        check("rst_busy", 1, busy_w[1], 1'b0);
        check("rst_in_ready", 1, in_ready_w[1], 1'b1);
        check("rst_out_state", 1, out_state_w[1], '0);
        tick();
        rst = 1'b0;
        tick();
        send(1, '0, 12);
        wait_out(1, cyc, st);
        check("post_rst_lat", 1, cyc, 6);
        check("post_rst_gold", 1, st, gold12);

        for (int k = 0; k < NI; k++) begin
            for (int j = 0; j < 6; j++) begin
                n = rpc_of(k) * int'($urandom_range(1, 12 / rpc_of(k)));
                send(k, rand_state(), n);
            end
        end
        for (int k = 0; k < NI; k++) wait_idle(k);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
